// File: rtl/piso_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx_if
//  Description : Word handshake and serial-output bundle for piso_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sdo;
  logic             sdo_valid;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sdo, sdo_valid, frame_start, frame_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sdo, sdo_valid, frame_start, frame_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx
//  Description : Parallel-in serial-out transmitter, one bit per clock, with
//                valid/ready word intake and back-to-back streaming.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  piso_tx_if.slave bus
);
  localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  localparam logic [0:0] c_idle  = 1'b0;
  localparam logic [0:0] c_shift = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;

  logic             w_in_shift;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic             w_bit;
  logic [WIDTH-1:0] w_shift_next;

  // The output end of the shift register depends on transmit order.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_bit        = r_shift[WIDTH-1];
      assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_bit        = r_shift[0];
      assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  assign w_in_shift = (r_state == c_shift);
  assign w_last     = w_in_shift && (r_cnt == c_last);
  assign w_ready    = !reset && ((r_state == c_idle) || w_last);
  assign w_accept   = bus.din_valid && w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_idle;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_shift <= bus.din;
            r_cnt   <= '0;
            r_state <= c_shift;
          end
        end
        c_shift: begin
          if (r_cnt != c_last) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + CW'(1);
          end else if (w_accept) begin
            r_shift <= bus.din;
            r_cnt   <= '0;
          end else begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_state <= c_idle;
          end
        end
        default: begin
          r_state <= c_idle;
          r_shift <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.din_ready   = w_ready;
  assign bus.sdo         = w_in_shift && w_bit;
  assign bus.sdo_valid   = w_in_shift;
  assign bus.busy        = w_in_shift;
  assign bus.frame_start = w_in_shift && (r_cnt == '0);
  assign bus.frame_done  = w_last;
endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_tx
//  Description : Directed bench for piso_tx in 4-bit MSB/LSB and 8-bit forms.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx;
  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  piso_tx_if #(.WIDTH(4)) b4 ();
  piso_tx_if #(.WIDTH(4)) bl ();
  piso_tx_if #(.WIDTH(8)) b8 ();

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb4 (.clk(clk), .reset(reset), .bus(b4));
  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb4 (.clk(clk), .reset(reset), .bus(bl));
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (.clk(clk), .reset(reset), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Left-shifting 4-bit receiver fed by the MSB-first transmitter.
  logic [3:0] rx4;
  always @(posedge clk) begin
    if (reset)            rx4 <= 4'h0;
    else if (b4.sdo_valid) rx4 <= {rx4[2:0], b4.sdo};
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  logic [7:0]  e8;
  logic [3:0]  e4;
  logic [15:0] e16;

  initial begin
    reset = 1'b1;
    b4.din = '0; b4.din_valid = 1'b0;
    bl.din = '0; bl.din_valid = 1'b0;
    b8.din = '0; b8.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready4", b4.din_ready, 0);
    check("rst_outs4", {b4.sdo, b4.sdo_valid, b4.busy, b4.frame_start, b4.frame_done}, 0);
    check("rst_outs8", {b8.din_ready, b8.sdo, b8.sdo_valid, b8.busy, b8.frame_done}, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", b4.din_ready, 1);

    // Single word 1011
    e4 = 4'b1011;
    b4.din = e4; b4.din_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("t1_sdo", b4.sdo, e4[3-j]);
      check("t1_valid", {b4.sdo_valid, b4.busy}, 2'b11);
      check("t1_flags", {b4.frame_start, b4.frame_done, b4.din_ready}, {j == 0, j == 3, j == 3});
      if (j == 0) begin b4.din_valid = 1'b0; b4.din = 4'h0; end
    end
    @(negedge clk);
    check("t1_idle", {b4.sdo, b4.sdo_valid, b4.busy, b4.frame_start, b4.frame_done}, 0);
    check("t1_rx", rx4, 4'b1011);

    // Back-to-back A then 5
    e8 = 8'hA5;
    b4.din = 4'hA; b4.din_valid = 1'b1;
    #1;
    check("t2_ready_k", b4.din_ready, 1);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check("t2_sdo", b4.sdo, e8[7-j]);
      check("t2_valid", b4.sdo_valid, 1);
      check("t2_ready", b4.din_ready, (j == 3) || (j == 7));
      check("t2_flags", {b4.frame_start, b4.frame_done}, {(j == 0) || (j == 4), (j == 3) || (j == 7)});
      if (j == 0) b4.din = 4'h5;
      if (j == 4) b4.din_valid = 1'b0;
    end
    @(negedge clk);
    check("t2_idle", {b4.sdo, b4.sdo_valid}, 0);
    check("t2_rx", rx4, 4'h5);

    // Backpressure: valid and a new din arrive mid-word
    e8 = 8'hC3;
    b4.din = 4'hC; b4.din_valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check("t3_sdo", b4.sdo, e8[7-j]);
      check("t3_ready", b4.din_ready, (j == 3) || (j == 7));
      check("t3_flags", {b4.frame_start, b4.frame_done}, {(j == 0) || (j == 4), (j == 3) || (j == 7)});
      if (j == 0) b4.din_valid = 1'b0;
      if (j == 1) begin b4.din_valid = 1'b1; b4.din = 4'h3; end
      if (j == 4) b4.din_valid = 1'b0;
    end
    @(negedge clk);
    check("t3_idle", {b4.sdo, b4.sdo_valid, b4.busy}, 0);

    // Reset at cnt=2 of word F, then word 3
    b4.din = 4'hF; b4.din_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("t4_sdo_f", b4.sdo, 1);
      if (j == 0) b4.din_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("t4_abandon", {b4.sdo, b4.sdo_valid, b4.busy, b4.frame_done, b4.din_ready}, 0);
    reset = 1'b0;
    e4 = 4'h3;
    b4.din = e4; b4.din_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("t4_sdo_3", b4.sdo, e4[3-j]);
      check("t4_flags", {b4.sdo_valid, b4.frame_start, b4.frame_done}, {1'b1, j == 0, j == 3});
      if (j == 0) b4.din_valid = 1'b0;
    end
    @(negedge clk);
    check("t4_idle", {b4.sdo, b4.sdo_valid}, 0);
    check("t4_rx", rx4, 4'h3);

    // LSB-first 0001
    e4 = 4'b0001;
    bl.din = e4; bl.din_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("t5_sdo", bl.sdo, e4[j]);
      check("t5_flags", {bl.sdo_valid, bl.frame_start, bl.frame_done}, {1'b1, j == 0, j == 3});
      if (j == 0) bl.din_valid = 1'b0;
    end
    @(negedge clk);
    check("t5_idle", {bl.sdo, bl.sdo_valid, bl.busy}, 0);

    // WIDTH=8: 81 then 7E back-to-back
    e16 = 16'h817E;
    b8.din = 8'h81; b8.din_valid = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      check("t6_sdo", b8.sdo, e16[15-j]);
      check("t6_valid", b8.sdo_valid, 1);
      check("t6_flags", {b8.frame_start, b8.frame_done, b8.din_ready},
            {(j == 0) || (j == 8), (j == 7) || (j == 15), (j == 7) || (j == 15)});
      if (j == 0) b8.din = 8'h7E;
      if (j == 8) b8.din_valid = 1'b0;
    end
    @(negedge clk);
    check("t6_idle", {b8.sdo, b8.sdo_valid, b8.busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
